// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   mdu_op_e    - decoder MDU op field (4 bits)
//   mdu_state_e - IDLE/BUSY control state
//   is_muldiv() - true for the four ops that open a busy window
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'b0000,
    MDU_MULTU = 4'b0001,
    MDU_DIV   = 4'b0010,
    MDU_DIVU  = 4'b0011,
    MDU_MFHI  = 4'b0100,
    MDU_MFLO  = 4'b0101,
    MDU_MTHI  = 4'b0110,
    MDU_MTLO  = 4'b0111,
    MDU_NONE  = 4'b1111
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  // mult/multu/div/divu all have op[3:2] == 00
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// mdu_timer: loadable down-counter that times the mult/div busy window.
//   clk, reset - clock, synchronous active-high reset (clears count)
//   load       - load load_val this cycle
//   load_val   - window length in cycles
//   busy       - count non-zero
//   done       - last busy cycle (count == 1); count reaches 0 at the next edge
module mdu_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)            cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit holding architectural HI/LO.
//   clk, reset - clock, synchronous active-high reset
//   op         - MDU op (mdu_pkg::mdu_op_e encoding)
//   start      - issue strobe for mult/multu/div/divu
//   A, B       - rs / rt operands
//   req        - (MDU_EXC_REQ_EN only) E instruction cancelled; suppress
//                start/mthi/mtlo this cycle
//   out        - HI for mfhi, LO for mflo, else 0 (combinational)
//   busy       - mult/div in flight
// Optional feature macro: MDU_EXC_REQ_EN (adds the req input).
// The result is computed on the issue cycle and parked in temp regs; it is
// copied to HI/LO on the last busy cycle, so out only ever shows committed
// values.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MDU_EXC_REQ_EN
  input  logic             req,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic req_i;
`ifdef MDU_EXC_REQ_EN
  assign req_i = req;
`else
  assign req_i = 1'b0;
`endif

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] thi_q, thi_d, tlo_q, tlo_d;
  logic             twr_q, twr_d;   // temp result is to be committed
  logic             accept, mt_ok, done;

  assign accept = (state_q == S_IDLE) && start && is_muldiv(op) && !req_i;
  assign mt_ok  = (state_q == S_IDLE) && !start && !req_i;

  // ---- arithmetic on issue-cycle operands ----
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   dvs_u, dvs_s;
  logic signed [WIDTH-1:0]   q_s, r_s;
  logic        [WIDTH-1:0]   q_u, r_u;
  logic                      div_ovf;

  assign prod_s  = $signed(A) * $signed(B);
  assign prod_u  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  // Dividing by 1 in the divide-by-zero case only keeps the divider
  // well-defined; the result is discarded (twr=0).
  assign dvs_u   = (B == '0) ? WIDTH'(1) : B;
  // MIN/-1 overflows; dividing MIN by 1 instead yields the required
  // LO=MIN, HI=0 with no extra result mux.
  assign div_ovf = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  assign dvs_s   = div_ovf ? WIDTH'(1) : dvs_u;
  assign q_s     = $signed(A) / $signed(dvs_s);
  assign r_s     = $signed(A) % $signed(dvs_s);
  assign q_u     = A / dvs_u;
  assign r_u     = A % dvs_u;

  mdu_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    twr_d   = twr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          twr_d   = 1'b1;
          case (op[1:0])
            2'b00:   {thi_d, tlo_d} = prod_s;
            2'b01:   {thi_d, tlo_d} = prod_u;
            2'b10: begin thi_d = r_s; tlo_d = q_s; twr_d = (B != '0); end
            default: begin thi_d = r_u; tlo_d = q_u; twr_d = (B != '0); end
          endcase
        end else if (mt_ok && op == MDU_MTHI) begin
          hi_d = A;
        end else if (mt_ok && op == MDU_MTLO) begin
          lo_d = A;
        end
      end
      S_BUSY: begin
        if (done) begin
          state_d = S_IDLE;
          if (twr_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      twr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
      twr_q   <= twr_d;
    end
  end

  always_comb begin
    out = '0;
    if (op == MDU_MFHI)      out = hi_q;
    else if (op == MDU_MFLO) out = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized + directed check of mdu against a behavioural model
// of HI/LO and the busy window built from plain 64-bit arithmetic.
module tb_mdu;
  localparam logic [3:0] OP_MULT = 4'h0, OP_MULTU = 4'h1, OP_DIV = 4'h2,
                         OP_DIVU = 4'h3, OP_MFHI = 4'h4, OP_MFLO = 4'h5,
                         OP_MTHI = 4'h6, OP_MTLO = 4'h7, OP_NONE = 4'hF;

  logic        clk = 1'b0;
  logic        reset, start, busy, req;
  logic [3:0]  op;
  logic [31:0] A, B, out;

  always #5 clk = ~clk;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef MDU_EXC_REQ_EN
    .req   (req),
`endif
    .out   (out),
    .busy  (busy)
  );

  // ---- model ----
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;
  int          m_cnt;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_out(input logic [3:0] o);
    if (o == OP_MFHI) return m_hi;
    if (o == OP_MFLO) return m_lo;
    return 32'h0;
  endfunction

  task automatic mdl_edge(input logic [3:0] o, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic r, input logic q);
    longint sa, sb;
    logic [63:0] p;
    if (r) begin
      m_hi = 0; m_lo = 0; m_cnt = 0; p_wr = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (!q) begin
      if (s && o <= OP_DIVU) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'h0;
        case (o)
          OP_MULT:  p = sa * sb;
          OP_MULTU: p = {32'h0, a} * {32'h0, b};
          OP_DIV:   if (b != 0) p = {32'(sa % sb), 32'(sa / sb)};
          default:  if (b != 0) p = {a % b, a / b};
        endcase
        {p_hi, p_lo} = p;
        p_wr  = !(o >= OP_DIV && b == 0);
        m_cnt = (o <= OP_MULTU) ? 5 : 10;
      end else if (!s && o == OP_MTHI) m_hi = a;
      else if (!s && o == OP_MTLO)     m_lo = a;
    end
  endtask

  // one clock: drive, check comb outputs, clock edge, advance model
  task automatic cyc(input logic [3:0] o, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic r = 1'b0, input logic q = 1'b0);
    op = o; start = s; A = a; B = b; reset = r;
`ifdef MDU_EXC_REQ_EN
    req = q;
`else
    req = 1'b0;
`endif
    #1;
    chk("busy", {31'h0, busy}, {31'h0, m_cnt != 0});
    chk("out", out, m_out(o));
    @(posedge clk);
    mdl_edge(o, s, a, b, r, req);
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] o, output logic [31:0] v);
    op = o; start = 1'b0; reset = 1'b0; req = 1'b0;
    #1;
    v = out;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      cyc(OP_NONE, 1'b0, $urandom, $urandom);
    end
  endtask

  logic [31:0] v, hi0, lo0;
  int n;

  initial begin
    op = OP_NONE; start = 0; A = 0; B = 0; reset = 1; req = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    m_hi = 0; m_lo = 0; m_cnt = 0; p_wr = 0;
    reset = 0;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rd(OP_MFHI, v); chk("rst_hi", v, 32'h0);
    rd(OP_MFLO, v); chk("rst_lo", v, 32'h0);

    // mult -3*7
    cyc(OP_MULT, 1, -32'sd3, 32'd7);
    wait_idle(n); chk("mult_lat", n, 5);
    rd(OP_MFHI, v); chk("mult_hi", v, 32'hFFFF_FFFF);
    rd(OP_MFLO, v); chk("mult_lo", v, 32'hFFFF_FFEB);
    rd(OP_MTHI, v); chk("out_other", v, 32'h0);

    // multu
    cyc(OP_MULTU, 1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n); chk("multu_lat", n, 5);
    rd(OP_MFHI, v); chk("multu_hi", v, 32'h1);
    rd(OP_MFLO, v); chk("multu_lo", v, 32'hFFFF_FFFE);

    // div -7/2, then divu by zero
    cyc(OP_DIV, 1, -32'sd7, 32'd2);
    wait_idle(n); chk("div_lat", n, 10);
    rd(OP_MFHI, v); chk("div_hi", v, 32'hFFFF_FFFF);
    rd(OP_MFLO, v); chk("div_lo", v, 32'hFFFF_FFFD);
    cyc(OP_DIVU, 1, 32'd7, 32'd0);
    wait_idle(n); chk("div0_lat", n, 10);
    rd(OP_MFHI, v); chk("div0_hi", v, 32'hFFFF_FFFF);
    rd(OP_MFLO, v); chk("div0_lo", v, 32'hFFFF_FFFD);

    // signed overflow
    cyc(OP_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    rd(OP_MFHI, v); chk("ovf_hi", v, 32'h0);
    rd(OP_MFLO, v); chk("ovf_lo", v, 32'h8000_0000);

    // mthi then mfhi
    cyc(OP_MTHI, 0, 32'h1234, 32'h0);
    rd(OP_MFHI, v); chk("mthi", v, 32'h1234);

    // second start at busy cycle 3 is ignored
    cyc(OP_DIV, 1, 32'd100, 32'd7);
    cyc(OP_NONE, 0, 0, 0);
    cyc(OP_NONE, 0, 0, 0);
    cyc(OP_MULT, 1, 32'd3, 32'd3);
    wait_idle(n); chk("restart_lat", n + 3, 10);
    rd(OP_MFLO, v); chk("restart_lo", v, 32'd14);
    rd(OP_MFHI, v); chk("restart_hi", v, 32'd2);

    // reset at busy cycle 2 aborts
    cyc(OP_MULT, 1, 32'd9, 32'd9);
    cyc(OP_NONE, 0, 0, 0);
    cyc(OP_NONE, 0, 0, 0, 1'b1);
    #1 chk("abort_busy", {31'h0, busy}, 32'h0);
    repeat (8) cyc(OP_NONE, 0, 0, 0);
    rd(OP_MFHI, v); chk("abort_hi", v, 32'h0);
    rd(OP_MFLO, v); chk("abort_lo", v, 32'h0);

`ifdef MDU_EXC_REQ_EN
    cyc(OP_MTLO, 0, 32'h55, 0);
    cyc(OP_MULT, 1, 32'd4, 32'd4, 1'b0, 1'b1);
    #1 chk("req_busy", {31'h0, busy}, 32'h0);
    cyc(OP_MTLO, 0, 32'hAA, 0, 1'b0, 1'b1);
    rd(OP_MFLO, v); chk("req_mtlo", v, 32'h55);
`endif

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  o;
      logic        s;
      logic [31:0] a, b;
      int k;
      k = $urandom_range(0, 9);
      if (k <= 3)      o = 4'(k);
      else if (k <= 7) o = 4'(k);
      else if (k == 8) o = OP_NONE;
      else             o = 4'($urandom_range(8, 14));
      s = (o <= OP_DIVU) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h1);
        default: ;
      endcase
      cyc(o, s, a, b, ($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
